// File: rtl/wb_project_decoder.sv
// Wishbone decoder for the project user area. Each 0x100-byte slot of the window is one project.
// Requests go to the selected slot, and a watchdog answers with ERR_DATA when a slot stays silent.
module wb_project_decoder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_SLOTS = 5,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [NUM_SLOTS-1:0]      slot_stb_o,
    output logic                      slot_we_o,
    output logic [3:0]                slot_sel_o,
    output logic [7:0]                slot_adr_o,
    output logic [31:0]               slot_dat_o,
    input  logic [NUM_SLOTS-1:0]      slot_ack_i,
    input  logic [32*NUM_SLOTS-1:0]   slot_dat_i,
    output logic [7:0]                err_count_o,
    output logic [31:0]               err_adr_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [3:0]            slot_q, slot_d;
    logic [31:0]           resp_q, resp_d;
    logic [NUM_SLOTS-1:0]  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [7:0]            adr_q, adr_d;
    logic [31:0]           dat_q, dat_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [31:0]           err_adr_q, err_adr_d;

    logic                  req, in_win, slot_ok, ack_sel;
    logic [3:0]            req_slot;
    logic [15:0]           ack_pad;
    logic [32*16-1:0]      dat_pad;
    logic [31:0]           slot_rdata;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Padding to the full 16-slot space lets a 4-bit slot index select without range issues.
    assign ack_pad    = 16'(slot_ack_i);
    assign dat_pad    = (32*16)'(slot_dat_i);
    assign ack_sel    = ack_pad[slot_q];
    assign slot_rdata = dat_pad[{slot_q, 5'b0} +: 32];

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign in_win   = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign req_slot = wbs_adr_i[11:8];
    assign slot_ok  = ({28'd0, req_slot} < NUM_SLOTS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        resp_d    = resp_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        case (state_q)
            IDLE: begin
                if (req && in_win) begin
                    if (slot_ok) begin
                        we_d    = wbs_we_i;
                        sel_d   = wbs_sel_i;
                        adr_d   = wbs_adr_i[7:0];
                        dat_d   = wbs_dat_i;
                        slot_d  = req_slot;
                        stb_d   = NUM_SLOTS'(16'd1 << req_slot);
                        cnt_d   = 8'd0;
                        state_d = ACTIVE;
                    end else begin
                        resp_d    = wbs_we_i ? 32'd0 : ERR_DATA;
                        err_cnt_d = sat_inc(err_cnt_q);
                        err_adr_d = wbs_adr_i;
                        state_d   = RESP;
                    end
                end
            end
            ACTIVE: begin
                // Abort outranks ack; an ack on the last watchdog cycle still beats the timeout.
                if (!wbs_cyc_i) begin
                    stb_d   = '0;
                    state_d = IDLE;
                end else if (ack_sel) begin
                    resp_d  = we_q ? 32'd0 : slot_rdata;
                    stb_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    resp_d    = we_q ? 32'd0 : ERR_DATA;
                    err_cnt_d = sat_inc(err_cnt_q);
                    err_adr_d = {BASE_ADDR[31:12], slot_q, adr_q};
                    stb_d     = '0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            resp_q    <= '0;
            stb_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            resp_q    <= resp_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign wbs_ack_o   = (state_q == RESP);
    assign wbs_dat_o   = wbs_ack_o ? resp_q : 32'd0;
    assign slot_stb_o  = stb_q;
    assign slot_we_o   = we_q;
    assign slot_sel_o  = sel_q;
    assign slot_adr_o  = adr_q;
    assign slot_dat_o  = dat_q;
    assign err_count_o = err_cnt_q;
    assign err_adr_o   = err_adr_q;

endmodule

// File: tb/tb_wb_project_decoder.sv
// Directed bench for wb_project_decoder: behavioural per-slot slaves plus a response scoreboard.
module tb_wb_project_decoder;

    localparam int NS  = 5;
    localparam int TO  = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]        sel = '0;
    logic [31:0]       adr = '0, wdat = '0;
    logic              ack_o;
    logic [31:0]       dat_o;
    logic [NS-1:0]     slot_stb;
    logic              slot_we;
    logic [3:0]        slot_sel;
    logic [7:0]        slot_adr;
    logic [31:0]       slot_wdat;
    logic [NS-1:0]     slot_ack;
    logic [32*NS-1:0]  slot_dat;
    logic [7:0]        err_count;
    logic [31:0]       err_adr;

    // Slave model: slot n acks when its strobe has been high for ack_dly[n] cycles (-1 = never).
    int                ack_dly [NS];
    int                scnt    [NS];
    logic [31:0]       rdata   [NS];
    logic [NS-1:0]     extra_ack = '0;

    typedef struct { logic [31:0] dat; int lat; } exp_t;
    exp_t sb [$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_project_decoder #(
        .BASE_ADDR(32'h3000_0000), .NUM_SLOTS(NS), .TIMEOUT(TO), .ERR_DATA(ERRD)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
        .slot_stb_o(slot_stb), .slot_we_o(slot_we), .slot_sel_o(slot_sel),
        .slot_adr_o(slot_adr), .slot_dat_o(slot_wdat),
        .slot_ack_i(slot_ack), .slot_dat_i(slot_dat),
        .err_count_o(err_count), .err_adr_o(err_adr)
    );

    always_ff @(posedge clk) begin
        for (int n = 0; n < NS; n++) scnt[n] <= slot_stb[n] ? scnt[n] + 1 : 0;
    end

    always_comb begin
        slot_ack = extra_ack;
        slot_dat = '0;
        for (int n = 0; n < NS; n++) begin
            slot_dat[32*n +: 32] = rdata[n];
            if (slot_stb[n] && ack_dly[n] >= 0 && scnt[n] == ack_dly[n]) slot_ack[n] = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One master transaction; the expected response is queued when the request is driven.
    task automatic txn(input string tag, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_ack, input logic [31:0] exp_dat,
                       input int exp_lat, output logic [NS-1:0] stb_seen);
        exp_t e;
        int   lat;
        logic got;
        lat = 0; got = 1'b0; stb_seen = '0;
        if (exp_ack) sb.push_back('{exp_dat, exp_lat});
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        @(posedge clk);
        for (int n = 1; n <= TO + 10; n++) begin
            @(negedge clk);
            stb_seen |= slot_stb;
            if (ack_o) begin lat = n; got = 1'b1; break; end
        end
        if (got) begin
            if (sb.size() == 0) begin
                chk({tag, "_spurious_ack"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_dat"}, dat_o, e.dat);
                chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
            end
        end else begin
            chk({tag, "_got_ack"}, {31'd0, got}, {31'd0, exp_ack});
            if (exp_ack && sb.size() != 0) void'(sb.pop_front());
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        if (got) begin
            @(negedge clk);
            chk({tag, "_ack_pulse"}, {31'd0, ack_o}, 32'd0);
            chk({tag, "_dat_idle"}, dat_o, 32'd0);
        end
    endtask

    logic [NS-1:0] seen;
    int            nack;

    initial begin
        for (int n = 0; n < NS; n++) begin
            ack_dly[n] = -1;
            rdata[n]   = 32'h1000_0000 + 32'(n);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_stb", 32'(slot_stb), 32'd0);
        chk("rst_slot_regs", {slot_we, 3'd0, slot_sel, slot_adr, 16'd0}, 32'd0);
        chk("rst_slot_dat", slot_wdat, 32'd0);
        chk("rst_err_cnt", 32'(err_count), 32'd0);
        chk("rst_err_adr", err_adr, 32'd0);

        // Combinational-ack read of slot 2
        ack_dly[2] = 0; rdata[2] = 32'h1234_5678;
        txn("rd_s2", 1'b0, 4'hF, 32'h3000_0218, 32'd0, 1'b1, 32'h1234_5678, 2, seen);
        chk("rd_s2_stb", 32'(seen), 32'h4);
        chk("rd_s2_adr", 32'(slot_adr), 32'h18);

        // Write to slot 1, slave acks after 3 cycles
        ack_dly[1] = 3;
        txn("wr_s1", 1'b1, 4'b0001, 32'h3000_0100, 32'h0000_00A5, 1'b1, 32'd0, 5, seen);
        chk("wr_s1_wdat", slot_wdat, 32'hA5);
        chk("wr_s1_we", {31'd0, slot_we}, 32'd1);
        chk("wr_s1_sel", 32'(slot_sel), 32'h1);
        chk("wr_s1_err_cnt", 32'(err_count), 32'd0);

        // Slot 3 never acks -> watchdog response
        txn("to_s3", 1'b0, 4'hF, 32'h3000_0300, 32'd0, 1'b1, ERRD, TO + 1, seen);
        chk("to_s3_err_cnt", 32'(err_count), 32'd1);
        chk("to_s3_err_adr", err_adr, 32'h3000_0300);

        // Unimplemented slot, then out-of-window
        txn("unimp", 1'b0, 4'hF, 32'h3000_0700, 32'd0, 1'b1, ERRD, 1, seen);
        chk("unimp_stb", 32'(seen), 32'd0);
        chk("unimp_err_cnt", 32'(err_count), 32'd2);
        chk("unimp_err_adr", err_adr, 32'h3000_0700);
        txn("unimp_wr", 1'b1, 4'hF, 32'h3000_0F00, 32'd0, 1'b1, 32'd0, 1, seen);
        chk("unimp_wr_err_cnt", 32'(err_count), 32'd3);
        txn("outwin", 1'b0, 4'hF, 32'h3000_1000, 32'd0, 1'b0, 32'd0, 0, seen);
        chk("outwin_stb", 32'(seen), 32'd0);
        chk("outwin_err_cnt", 32'(err_count), 32'd3);

        // Ack on the last watchdog cycle wins; acks from other slots are ignored
        ack_dly[0] = TO - 1; rdata[0] = 32'hCAFE_0000;
        txn("late_s0", 1'b0, 4'hF, 32'h3000_0004, 32'd0, 1'b1, 32'hCAFE_0000, TO + 1, seen);
        chk("late_s0_err_cnt", 32'(err_count), 32'd3);
        ack_dly[0] = 3; extra_ack = 5'b10000;
        txn("other_ack", 1'b0, 4'hF, 32'h3000_0008, 32'd0, 1'b1, 32'hCAFE_0000, 5, seen);
        extra_ack = '0;

        // Abort by dropping cyc mid-ACTIVE
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0300;
        repeat (4) @(posedge clk);
        #1 cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_stb", 32'(slot_stb), 32'd0);
        nack = 0;
        for (int n = 0; n < TO + 5; n++) begin @(negedge clk); if (ack_o) nack++; end
        chk("abort_no_ack", 32'(nack), 32'd0);
        chk("abort_err_cnt", 32'(err_count), 32'd3);

        // Reset mid-ACTIVE
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0300;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("rstmid_stb", 32'(slot_stb), 32'd0);
        nack = 0;
        for (int n = 0; n < TO + 5; n++) begin @(negedge clk); if (ack_o) nack++; end
        chk("rstmid_no_ack", 32'(nack), 32'd0);
        chk("rstmid_err_cnt", 32'(err_count), 32'd0);

        txn("after_rst", 1'b0, 4'hF, 32'h3000_0218, 32'd0, 1'b1, 32'h1234_5678, 2, seen);

        // Saturation of the error counter
        for (int k = 0; k < 300; k++)
            txn("sat", 1'b0, 4'hF, 32'h3000_0300, 32'd0, 1'b1, ERRD, TO + 1, seen);
        chk("sat_err_cnt", 32'(err_count), 32'd255);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
